// File: rtl/pwm_deadtime_gen_if.sv
// Shadow-load bus for the dead-time PWM stage.
// The host drives the compare/dead-time values and the load strobe; the stage reports pending/ack.
interface pwm_deadtime_gen_if #(
    parameter int WIDTH    = 16,
    parameter int DT_WIDTH = 8
);
    logic [WIDTH-1:0]    cmp_in;
    logic [DT_WIDTH-1:0] dt_in;
    logic                load;
    logic                pending;
    logic                load_ack;

    modport master (output cmp_in, dt_in, load, input pending, load_ack);
    modport slave  (input cmp_in, dt_in, load, output pending, load_ack);
endinterface

// File: rtl/pwm_deadtime_gen.sv
// Center-aligned complementary PWM with valley-synchronous shadow loading
// and programmable dead time between the high-side and low-side drives.
module pwm_deadtime_gen #(
    parameter int WIDTH    = 16,
    parameter int DT_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count,
    input  logic              up_down,
    input  logic              enable,
    pwm_deadtime_gen_if.slave ld,
    output logic              pwm_hi,
    output logic              pwm_lo
);
    typedef struct packed {
        logic [WIDTH-1:0]    cmp;
        logic [DT_WIDTH-1:0] dt;
    } cfg_t;

    typedef enum logic [2:0] {OFF, DT_TO_HI, HI_ON, DT_TO_LO, LO_ON} state_t;

    cfg_t                shadow, active;
    logic                pending_q, ack_q;
    logic                dir_q, raw_q;
    logic                apply;
    state_t              state, nxt;
    logic [DT_WIDTH-1:0] dt_cnt;
    logic                from_off;
    logic                in_dt, dt_zero;

    assign apply       = (~dir_q & up_down) | ~enable;
    assign ld.pending  = pending_q;
    assign ld.load_ack = ack_q;
    assign in_dt       = (state == DT_TO_HI) || (state == DT_TO_LO);
    assign dt_zero     = (active.dt == '0);

    // Shadow/active configuration; the active set only changes at a valley or while disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow    <= '0;
            active    <= '{cmp: '0, dt: '1};
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            dir_q     <= 1'b0;
            raw_q     <= 1'b0;
        end else begin
            dir_q <= up_down;
            raw_q <= enable && (count < active.cmp);
            ack_q <= apply && pending_q;
            if (apply && pending_q)
                active <= shadow;
            if (ld.load) begin
                shadow    <= '{cmp: ld.cmp_in, dt: ld.dt_in};
                pending_q <= 1'b1;
            end else if (apply) begin
                pending_q <= 1'b0;
            end
        end
    end

    // A gap entered from OFF has no side to fall back to, so it just runs out its
    // count and lands on whichever side the demand asks for at that point.
    always_comb begin
        nxt = state;
        if (!enable) begin
            nxt = OFF;
        end else begin
            case (state)
                OFF:      if (raw_q) nxt = dt_zero ? HI_ON : DT_TO_HI;
                          else       nxt = dt_zero ? LO_ON : DT_TO_LO;
                HI_ON:    if (!raw_q) nxt = dt_zero ? LO_ON : DT_TO_LO;
                LO_ON:    if (raw_q)  nxt = dt_zero ? HI_ON : DT_TO_HI;
                DT_TO_LO: if (raw_q && !from_off) nxt = HI_ON;
                          else if (dt_cnt == '0)  nxt = raw_q ? HI_ON : LO_ON;
                          else                    nxt = raw_q ? DT_TO_HI : DT_TO_LO;
                DT_TO_HI: if (!raw_q && !from_off) nxt = LO_ON;
                          else if (dt_cnt == '0)   nxt = raw_q ? HI_ON : LO_ON;
                          else                     nxt = raw_q ? DT_TO_HI : DT_TO_LO;
                default:  nxt = OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= OFF;
            pwm_hi   <= 1'b0;
            pwm_lo   <= 1'b0;
            dt_cnt   <= '0;
            from_off <= 1'b0;
        end else begin
            state  <= nxt;
            pwm_hi <= (nxt == HI_ON);
            pwm_lo <= (nxt == LO_ON);
            // Counter preloads with dt-1 so the gap lasts exactly dt cycles.
            if (!in_dt) begin
                dt_cnt   <= active.dt - 1'b1;
                from_off <= (state == OFF);
            end else begin
                dt_cnt <= dt_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Randomized scoreboard bench for pwm_deadtime_gen: a cycle-level intent model
// predicts outputs each edge; a negedge monitor pops and compares.
module tb_pwm_deadtime_gen;
    localparam int WIDTH    = 16;
    localparam int DT_WIDTH = 8;
    localparam int unsigned TOP  = 32'h400;
    localparam int unsigned STEP = 32'h20;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] count = '0;
    logic             up_down = 1'b0;
    logic             enable = 1'b0;
    logic             pwm_hi, pwm_lo;

    pwm_deadtime_gen_if #(.WIDTH(WIDTH), .DT_WIDTH(DT_WIDTH)) ld ();

    pwm_deadtime_gen #(.WIDTH(WIDTH), .DT_WIDTH(DT_WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .count   (count),
        .up_down (up_down),
        .enable  (enable),
        .ld      (ld),
        .pwm_hi  (pwm_hi),
        .pwm_lo  (pwm_lo)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {logic hi; logic lo; logic pend; logic ack;} exp_t;
    exp_t q[$];

    // Count source: a triangle ramp, or a jittery count around 0x100 to provoke glitches.
    bit          jitter = 1'b0;
    int unsigned tri_cnt = 0;
    bit          tri_up = 1'b0;
    always @(posedge clk) begin
        #2;
        if (jitter) begin
            count   = ($urandom_range(0, 1) == 1) ? 16'h00FE : 16'h0102;
            up_down = 1'($urandom_range(0, 1));
        end else begin
            if (tri_up) begin
                if (tri_cnt >= TOP) begin tri_up = 1'b0; tri_cnt -= STEP; end
                else tri_cnt += STEP;
            end else begin
                if (tri_cnt == 0) begin tri_up = 1'b1; tri_cnt += STEP; end
                else tri_cnt -= STEP;
            end
            count   = WIDTH'(tri_cnt);
            up_down = tri_up;
        end
    end

    // Reference model: output intent is off / on(side) / gap(counting cycles).
    // side: 1 = high, 2 = low.
    bit          m_dir, m_raw, m_pend, m_ack;
    int unsigned m_cmp, m_dt, s_cmp, s_dt;
    int          mode, side, prev, gap_left;
    bit          gap_off;

    always @(posedge clk or negedge reset) begin
        int want;
        bit apply;
        bit n_ack;
        if (!reset) begin
            m_dir = 0; m_raw = 0; m_pend = 0; m_ack = 0;
            m_cmp = 0; m_dt = 255; s_cmp = 0; s_dt = 0;
            mode = 0; side = 0; prev = 0; gap_left = 0; gap_off = 0;
            q.delete();
        end else begin
            want = m_raw ? 1 : 2;
            if (!enable) mode = 0;
            else case (mode)
                0: if (m_dt == 0) begin mode = 1; side = want; end
                   else begin mode = 2; gap_left = int'(m_dt); gap_off = 1; end
                1: if (want != side) begin
                       if (m_dt == 0) side = want;
                       else begin mode = 2; prev = side; gap_left = int'(m_dt); gap_off = 0; end
                   end
                default: if (!gap_off && want == prev) begin mode = 1; side = prev; end
                         else begin
                             gap_left--;
                             if (gap_left == 0) begin mode = 1; side = want; end
                         end
            endcase
            m_raw = enable && (int'(count) < int'(m_cmp));
            apply = (!m_dir && up_down) || !enable;
            n_ack = apply && m_pend;
            if (apply && m_pend) begin m_cmp = s_cmp; m_dt = s_dt; end
            if (ld.load) begin
                m_pend = 1; s_cmp = ld.cmp_in; s_dt = ld.dt_in;
            end else if (apply) m_pend = 0;
            m_ack = n_ack;
            m_dir = up_down;
            q.push_back('{hi: (mode == 1 && side == 1), lo: (mode == 1 && side == 2),
                          pend: m_pend, ack: m_ack});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset && q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({pwm_hi, pwm_lo, ld.pending, ld.load_ack} !== e) begin
                errors++;
                $display("FAIL cycle hi/lo/pend/ack: actual=%b required=%b at %0t",
                         {pwm_hi, pwm_lo, ld.pending, ld.load_ack}, e, $time);
            end
            checks++;
            if (pwm_hi && pwm_lo) begin
                errors++;
                $display("FAIL overlap: hi=%b lo=%b required not both at %0t", pwm_hi, pwm_lo, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_load(input logic [WIDTH-1:0] c, input logic [DT_WIDTH-1:0] d);
        @(negedge clk);
        ld.load = 1'b1; ld.cmp_in = c; ld.dt_in = d;
        @(negedge clk);
        ld.load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_down(input string name);
        int i;
        for (i = 0; i < 200 && up_down; i++) @(negedge clk);
        if (up_down) chk(name, 32'(up_down), 0);
    endtask

    task automatic wait_hi(input string name);
        int i;
        for (i = 0; i < 2000 && !pwm_hi; i++) @(negedge clk);
        if (!pwm_hi) chk(name, 32'(pwm_hi), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ld.load = 1'b0; ld.cmp_in = '0; ld.dt_in = '0;
        idle(3);
        chk("rst_hi",   32'(pwm_hi),      0);
        chk("rst_lo",   32'(pwm_lo),      0);
        chk("rst_pend", 32'(ld.pending),  0);
        chk("rst_ack",  32'(ld.load_ack), 0);
        #2 reset = 1'b1;
        enable = 1'b1;
        idle(300);

        // Shadowed load during a down ramp, then dead time of 3.
        wait_down("wait_down_a");
        do_load(16'h0100, 8'd3);
        chk("pend_after_load", 32'(ld.pending), 1);
        idle(300);

        do_load(16'h0100, 8'd0);        // zero dead time
        idle(200);

        wait_down("wait_down_b");
        do_load(16'h0200, 8'd2);        // overwritten before the valley
        idle(2);
        do_load(16'h0300, 8'd2);
        idle(200);

        do_load(16'h0000, 8'd1);        // never high
        idle(200);
        do_load(16'hFFFF, 8'd2);        // high except at max
        idle(200);

        // Load landing exactly on the apply edge.
        do_load(16'h0180, 8'd3);
        idle(2);
        for (n = 0; n < 200 && !(count == '0 && !up_down); n++) @(negedge clk);
        do_load(16'h0240, 8'd2);
        idle(200);

        // Enable drop in HI_ON applies a pending load; re-enable with dt=4.
        do_load(16'h0180, 8'd4);
        idle(200);
        do_load(16'h0200, 8'd4);
        wait_hi("wait_hi_en");
        enable = 1'b0;
        idle(3);
        enable = 1'b1;
        idle(150);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            ld.load = 1'b0;
            if ($urandom_range(0, 29) == 0) begin
                n = int'($urandom_range(0, 9));
                ld.load   = 1'b1;
                ld.cmp_in = (n == 0) ? 16'h0000 : (n == 1) ? 16'hFFFF : 16'($urandom_range(0, 16'h440));
                ld.dt_in  = 8'($urandom_range(0, 7));
            end else if ($urandom_range(0, 199) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                enable = 1'b1;
            end
        end
        ld.load = 1'b0;

        // Jittery demand around the compare point: glitch aborts in dead time.
        do_load(16'h0100, 8'd5);
        idle(200);
        jitter = 1'b1;
        idle(300);
        do_load(16'h0100, 8'd2);
        idle(200);
        jitter = 1'b0;
        idle(100);

        // Async reset while high, then the full 255-cycle safe dead time.
        do_load(16'h0200, 8'd2);
        idle(150);
        wait_hi("wait_hi_rst");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_hi",   32'(pwm_hi),      0);
        chk("async_lo",   32'(pwm_lo),      0);
        chk("async_pend", 32'(ld.pending),  0);
        chk("async_ack",  32'(ld.load_ack), 0);
        idle(2);
        #2 reset = 1'b1;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pwm_lo) break;
            n++;
        end
        chk("startup_dt_cycles", 32'(n), 255);
        idle(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pwm_deadtime_gen.md
# pwm_deadtime_gen

Center-aligned complementary PWM stage that consumes the running count of the 16-bit up/down counter and its `up_down` direction control. Compares the count against a double-buffered compare value to form a raw demand, then drives a high-side/low-side output pair with programmable dead time so both sides are never on together. Compare and dead-time updates are staged in shadow registers and applied only at the triangle valley, so no pulse is ever torn mid-period.

## Interface
- `WIDTH`, 16, count and compare width; matches the counter output.
- `DT_WIDTH`, 8, dead-time counter width.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `count`  in  WIDTH  counter value, the counter's `out`.
- `up_down`  in  1  the same direction control driven into the counter (1 = up).
- `enable`  in  1  output enable; 0 forces both outputs low.
- `cmp_in`  in  WIDTH  new compare value.
- `dt_in`  in  DT_WIDTH  new dead time, in clk cycles.
- `load`  in  1  single-cycle strobe that captures `cmp_in`/`dt_in` into the shadow registers.
- `pending`  out  1  shadow holds values not yet applied.
- `load_ack`  out  1  one-cycle pulse on the cycle the shadow values become active.
- `pwm_hi`  out  1  high-side drive.
- `pwm_lo`  out  1  low-side drive.

## Operation
- **Reset values:**
  - `pwm_hi`, `pwm_lo`, `pending`, `load_ack` = 0.
  - FSM in OFF.
  - `cmp_active` = 0; `dt_active` = all ones (maximum dead time, safe default).
  - Shadow registers = 0; `dir_q` = 0; `raw_q` = 0.
- **Shadow load:**
  - `load`=1 writes `cmp_in`/`dt_in` to the shadow and sets `pending`.
  - A further `load` while pending overwrites the shadow; the latest value wins.
- **Apply condition:** valley detect (`dir_q`=0 and `up_down`=1), or `enable`=0.
  - On apply with `pending`=1: active ← shadow, `pending` ← 0, `load_ack` pulses for one cycle.
  - `load` in the same cycle as apply: the pre-cycle shadow is applied, the new value goes to the shadow, and `pending` stays 1.
- **Raw demand:** `raw_q` ← `enable` && (`count` < `cmp_active`), unsigned compare.
  - `cmp_active`=0 means never high.
  - `cmp_active` = 2^WIDTH−1 means high at every count except the maximum.
- **FSM states:** OFF, DT_TO_HI, HI_ON, DT_TO_LO, LO_ON.
  - **OFF:** both outputs low. When `enable`=1, go to DT_TO_HI if `raw_q`=1, else DT_TO_LO.
  - **HI_ON** (hi=1, lo=0): if `raw_q`=0, go to DT_TO_LO (or directly to LO_ON if `dt_active`=0).
  - **LO_ON** (hi=0, lo=1): if `raw_q`=1, go to DT_TO_HI (or directly to HI_ON if `dt_active`=0).
  - **DT_TO_LO / DT_TO_HI:** both outputs low. Dead-time counter loaded with `dt_active` on entry and decremented each cycle. Exit to LO_ON / HI_ON after exactly `dt_active` cycles in the state.
  - If `raw_q` reverts during dead time, return to the previous ON state on the next edge; the opposite side never asserts.
  - `dt_active`=0 when leaving OFF: go directly to the ON state.
  - `enable`=0 from any state: OFF on the next edge.
- **Invariant:** `pwm_hi` && `pwm_lo` is never 1, in every cycle and through every transition.
- **Outputs:** `pwm_hi`/`pwm_lo` are registered and decoded from the next state; no combinational path from inputs.
- **Reset mid-operation:** outputs drop asynchronously. After reset release the FSM starts in OFF and inserts the full `dt_active` (all ones) before any side turns on, until a load is applied.

## Timing
- `count` changes before edge E0 → `raw_q` updates at E0 → ON-side output falls at E1.
- Opposite side rises at E1 + `dt_active`; with dead time 0 it rises at E1, the same edge the other side falls.
- Apply happens on the edge that samples `up_down`=1 with `dir_q`=0. New `cmp_active` affects `raw_q` from the following edge.
- `load_ack` is high for exactly one cycle per apply; there is no ack for a load that is later overwritten.
- `enable` falls before edge E → both outputs low from E.

## Test plan
- **Async reset:** assert `reset`=0 between edges while `pwm_hi`=1 → `pwm_hi`, `pwm_lo`, `pending`, `load_ack` all 0 immediately. After release with `enable`=1 and `raw_q`=0, `pwm_lo` rises 255 cycles after entering DT_TO_LO.
- **Shadowed load:** during a down ramp, pulse `load` with `cmp_in`=0x0100, `dt_in`=3 → `pending`=1. Count continues down and `up_down` goes 0→1 → `load_ack` high for exactly one cycle, `pending` 0, new compare in effect from the next cycle.
- **Dead time:** `cmp_active`=0x0100, `dt_active`=3, count rising through 0x0100 → `pwm_hi` falls one edge after `raw_q` clears, both outputs low for exactly 3 cycles, then `pwm_lo`=1. Falling back through 0x00FF gives the mirror response.
- **Zero dead time and glitch abort:**
  - `dt_active`=0 → `pwm_hi` falls and `pwm_lo` rises on the same edge; never both high.
  - `dt_active`=5 with `raw_q` toggling 1→0→1 within 2 cycles → returns to HI_ON; `pwm_lo` never asserts.
- **Boundaries:**
  - `cmp_active`=0 → `pwm_hi` never asserts.
  - Two loads (0x0200, then 0x0300) before one valley → only 0x0300 applied, one `load_ack`.
  - `load` on the apply cycle → `pending` stays 1.
- **Enable:** drop `enable` in HI_ON → both outputs 0 on the next edge and a pending load is applied. Re-enable with `dt_active`=4 → 4 cycles both low before the ON side asserts.
